// File: rtl/sha256_ctrl_pkg.sv
// Shared state encoding and block-level constants for the SHA-256 controller.
// Optional build macro used by users of this package: SHA_CTRL_CYCLE_CNT_EN.
package sha_pkg;

  localparam int NUM_HWORDS = 8;
  localparam int NUM_MWORDS = 16;
  localparam int NUM_ROUNDS = 64;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_H = 3'd1;
  localparam state_t ST_GAP_H  = 3'd2;
  localparam state_t ST_ROUND  = 3'd3;
  localparam state_t ST_GAP_R  = 3'd4;
  localparam state_t ST_FINAL  = 3'd5;
  localparam state_t ST_DRAIN  = 3'd6;
  localparam state_t ST_DONE   = 3'd7;

endpackage

// File: rtl/sha256_ctrl_if.sv
// Controller-side bundle: start/finish handshake plus hmem/kmem/msg/dom strobes and addresses.
// SHA_CTRL_CYCLE_CNT_EN adds the cycle_count observation bus.
interface sha256_ctrl_if #(
  parameter int HW_ADDR = 3,
  parameter int K_ADDR  = 6,
  parameter int M_ADDR  = 4
);
  logic               dut__xxx__start;
  logic               dut__xxx__finish;
  logic               H_read;
  logic               H_iterate;
  logic [HW_ADDR-1:0] dut__hmem__address;
  logic [K_ADDR-1:0]  dut__kmem__address;
  logic [M_ADDR-1:0]  dut__msg__address;
  logic               w_load;
  logic [HW_ADDR-1:0] dut__dom__address;
  logic               dut__dom__write;
  logic               busy;
`ifdef SHA_CTRL_CYCLE_CNT_EN
  logic [15:0]        cycle_count;
`endif

  modport master (
    input  dut__xxx__start,
    output dut__xxx__finish, H_read, H_iterate,
    output dut__hmem__address, dut__kmem__address, dut__msg__address, w_load,
    output dut__dom__address, dut__dom__write, busy
`ifdef SHA_CTRL_CYCLE_CNT_EN
    , output cycle_count
`endif
  );

  modport slave (
    output dut__xxx__start,
    input  dut__xxx__finish, H_read, H_iterate,
    input  dut__hmem__address, dut__kmem__address, dut__msg__address, w_load,
    input  dut__dom__address, dut__dom__write, busy
`ifdef SHA_CTRL_CYCLE_CNT_EN
    , input cycle_count
`endif
  );

endinterface

// File: rtl/sha256_ctrl_outpipe.sv
// DEPTH-stage valid/address shift register aligning dom writes with datapath output latency.
// Synchronous clear empties every stage; addresses of empty stages are zero.
module sha256_ctrl_outpipe #(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld_sr;
  logic [AW-1:0]    addr_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= in_vld;
      addr_sr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_addr = addr_sr[DEPTH-1];

endmodule

// File: rtl/sha256_ctrl.sv
// SHA-256 compression sequencer: load H, ROUNDS round cycles, finalise, stream 8 words to dom, pulse finish.
// Optional macro SHA_CTRL_CYCLE_CNT_EN adds a saturating 16-bit busy-cycle counter.
module sha256_ctrl
  import sha_pkg::*;
#(
  parameter int ROUNDS  = NUM_ROUNDS,
  parameter int OUT_LAT = 2,
  parameter int HW_ADDR = 3,
  parameter int K_ADDR  = 6,
  parameter int M_ADDR  = 4
) (
  input logic           clk,
  input logic           reset,
  sha256_ctrl_if.master bus
);

  localparam int CNT_W = (K_ADDR > 6) ? K_ADDR : 6;
  localparam logic [CNT_W-1:0] LAST_HWORD = CNT_W'(NUM_HWORDS - 1);
  localparam logic [CNT_W-1:0] LAST_MSG   = CNT_W'(NUM_MWORDS - 1);
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(OUT_LAT - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               finish_q, h_read_q, h_iterate_q, w_load_q, busy_q;
  logic [HW_ADDR-1:0] hmem_addr_q;
  logic [K_ADDR-1:0]  kmem_addr_q;
  logic [M_ADDR-1:0]  msg_addr_q;
  logic               push_vld;
  logic [HW_ADDR-1:0] push_addr;

  // Every phase exits on its terminal count, and cnt restarts from zero on each state change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.dut__xxx__start) state_nxt = ST_LOAD_H;
      end
      ST_LOAD_H: if (cnt == LAST_HWORD) begin
        state_nxt = ST_GAP_H;
        cnt_nxt   = '0;
      end
      ST_GAP_H: begin
        state_nxt = ST_ROUND;
        cnt_nxt   = '0;
      end
      ST_ROUND: if (cnt == LAST_ROUND) begin
        state_nxt = ST_GAP_R;
        cnt_nxt   = '0;
      end
      ST_GAP_R: begin
        state_nxt = ST_FINAL;
        cnt_nxt   = '0;
      end
      ST_FINAL: if (cnt == LAST_HWORD) begin
        state_nxt = ST_DRAIN;
        cnt_nxt   = '0;
      end
      ST_DRAIN: if (cnt == LAST_DRAIN) begin
        state_nxt = ST_DONE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      finish_q    <= 1'b0;
      h_read_q    <= 1'b0;
      h_iterate_q <= 1'b0;
      w_load_q    <= 1'b0;
      busy_q      <= 1'b0;
      hmem_addr_q <= '0;
      kmem_addr_q <= '0;
      msg_addr_q  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      finish_q    <= (state_nxt == ST_DONE);
      busy_q      <= (state_nxt != ST_IDLE);
      h_read_q    <= (state_nxt == ST_LOAD_H) || (state_nxt == ST_FINAL);
      hmem_addr_q <= ((state_nxt == ST_LOAD_H) || (state_nxt == ST_FINAL))
                     ? cnt_nxt[HW_ADDR-1:0] : '0;
      h_iterate_q <= (state_nxt == ST_ROUND);
      kmem_addr_q <= (state_nxt == ST_ROUND) ? cnt_nxt[K_ADDR-1:0] : '0;
      w_load_q    <= (state_nxt == ST_ROUND) && (cnt_nxt <= LAST_MSG);
      msg_addr_q  <= ((state_nxt == ST_ROUND) && (cnt_nxt <= LAST_MSG))
                     ? cnt_nxt[M_ADDR-1:0] : '0;
    end
  end

  assign push_vld  = (state == ST_FINAL);
  assign push_addr = push_vld ? hmem_addr_q : '0;

  sha256_ctrl_outpipe #(
    .DEPTH (OUT_LAT),
    .AW    (HW_ADDR)
  ) u_outpipe (
    .clk      (clk),
    .clr      (reset),
    .in_vld   (push_vld),
    .in_addr  (push_addr),
    .out_vld  (bus.dut__dom__write),
    .out_addr (bus.dut__dom__address)
  );

  assign bus.dut__xxx__finish   = finish_q;
  assign bus.H_read             = h_read_q;
  assign bus.H_iterate          = h_iterate_q;
  assign bus.dut__hmem__address = hmem_addr_q;
  assign bus.dut__kmem__address = kmem_addr_q;
  assign bus.dut__msg__address  = msg_addr_q;
  assign bus.w_load             = w_load_q;
  assign bus.busy               = busy_q;

`ifdef SHA_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if ((state == ST_IDLE) && bus.dut__xxx__start) begin
      cycle_cnt_q <= '0;
    end else if ((state != ST_IDLE) && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_ctrl.sv
// Randomised scoreboard bench for sha256_ctrl: a timeline model queues expected strobes per accepted start.
// Stimulus: single pulses, random start noise while busy, reset mid-round, start held high, sparse random starts.
module tb_sha256_ctrl;

  localparam int R   = 64;
  localparam int L   = 2;
  localparam int FIN = R + L + 18;   // finish offset from the accepting edge

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_ctrl_if #(.HW_ADDR(3), .K_ADDR(6), .M_ADDR(4)) bus();

  sha256_ctrl #(
    .ROUNDS(R), .OUT_LAT(L), .HW_ADDR(3), .K_ADDR(6), .M_ADDR(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct { int t; int a; } ev_t;
  typedef struct { int t; int k; int m; int wl; } rnd_t;

  ev_t  q_hr[$];
  ev_t  q_dom[$];
  rnd_t q_rnd[$];
  int   q_fin[$];

  int edge_n = 0;
  int free_edge = 0;
  int bs_lo = 0, bs_hi = -1;
  int rst_edge = -1;
  int cc_s = 0;
  bit cc_vld = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Reference timeline: for a start accepted at edge S, strobe k of the spec's cycle table shows at edge S+k-1.
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      q_hr.delete(); q_dom.delete(); q_rnd.delete(); q_fin.delete();
      free_edge = edge_n + 1;
      bs_hi = edge_n - 1;
      rst_edge = edge_n;
      cc_vld = 1'b0;
    end else if (bus.dut__xxx__start && edge_n >= free_edge) begin
      ev_t  e;
      rnd_t r;
      for (int i = 0; i < 8; i++) begin
        e.t = edge_n + i; e.a = i; q_hr.push_back(e);
      end
      for (int i = 0; i < R; i++) begin
        r.t = edge_n + 9 + i; r.k = i;
        r.wl = (i < 16) ? 1 : 0;
        r.m = (i < 16) ? i : 0;
        q_rnd.push_back(r);
      end
      for (int i = 0; i < 8; i++) begin
        e.t = edge_n + 10 + R + i; e.a = i; q_hr.push_back(e);
        e.t = edge_n + 10 + R + L + i; q_dom.push_back(e);
      end
      q_fin.push_back(edge_n + FIN);
      bs_lo = edge_n;
      bs_hi = edge_n + FIN;
      free_edge = edge_n + FIN + 2;
      cc_s = edge_n;
      cc_vld = 1'b1;
    end
  end

  // Monitor: pops the expected event whenever the DUT raises a strobe; overdue entries count as missed.
  always @(negedge clk) begin
    if (edge_n >= 1) begin
      int t;
      t = edge_n;
      if (rst_edge == t)
        check("reset_zero", int'({bus.dut__xxx__finish, bus.H_read, bus.H_iterate, bus.w_load,
              bus.dut__dom__write, bus.busy, bus.dut__hmem__address, bus.dut__kmem__address,
              bus.dut__msg__address, bus.dut__dom__address}), 0);
      check("busy", int'(bus.busy), (t >= bs_lo && t <= bs_hi) ? 1 : 0);

      if (bus.H_read) begin
        if (q_hr.size() == 0) check("hread_unexpected", 1, 0);
        else begin
          ev_t e;
          e = q_hr.pop_front();
          check("hread_time", t, e.t);
          check("hmem_addr", int'(bus.dut__hmem__address), e.a);
        end
      end else check("hmem_idle", int'(bus.dut__hmem__address), 0);
      while (q_hr.size() > 0 && q_hr[0].t <= t) begin
        check("hread_missed", t, q_hr[0].t - 1);
        void'(q_hr.pop_front());
      end

      if (bus.H_iterate) begin
        if (q_rnd.size() == 0) check("round_unexpected", 1, 0);
        else begin
          rnd_t r;
          r = q_rnd.pop_front();
          check("round_time", t, r.t);
          check("kmem_addr", int'(bus.dut__kmem__address), r.k);
          check("msg_addr", int'(bus.dut__msg__address), r.m);
          check("w_load", int'(bus.w_load), r.wl);
        end
      end else begin
        check("kmem_idle", int'(bus.dut__kmem__address), 0);
        check("msg_idle", int'(bus.dut__msg__address), 0);
        check("w_load_idle", int'(bus.w_load), 0);
      end
      while (q_rnd.size() > 0 && q_rnd[0].t <= t) begin
        check("round_missed", t, q_rnd[0].t - 1);
        void'(q_rnd.pop_front());
      end

      if (bus.dut__dom__write) begin
        if (q_dom.size() == 0) check("dom_unexpected", 1, 0);
        else begin
          ev_t e;
          e = q_dom.pop_front();
          check("dom_time", t, e.t);
          check("dom_addr", int'(bus.dut__dom__address), e.a);
        end
      end else check("dom_idle", int'(bus.dut__dom__address), 0);
      while (q_dom.size() > 0 && q_dom[0].t <= t) begin
        check("dom_missed", t, q_dom[0].t - 1);
        void'(q_dom.pop_front());
      end

      if (bus.dut__xxx__finish) begin
        if (q_fin.size() == 0) check("finish_unexpected", 1, 0);
        else check("finish_time", t, q_fin.pop_front());
      end
      while (q_fin.size() > 0 && q_fin[0] <= t) begin
        check("finish_missed", t, q_fin[0] - 1);
        void'(q_fin.pop_front());
      end

`ifdef SHA_CTRL_CYCLE_CNT_EN
      check("cycle_count", int'(bus.cycle_count),
            cc_vld ? (((t - cc_s) > FIN + 1) ? FIN + 1 : (t - cc_s)) : 0);
`endif
    end
  end

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.dut__xxx__start = 1'b0;
    idle_wait(3);
    reset = 1'b0;
    idle_wait(2);

    // single pulse, full run
    bus.dut__xxx__start = 1'b1;
    idle_wait(1);
    bus.dut__xxx__start = 1'b0;
    idle_wait(95);

    // pulse then random start noise across a whole run
    bus.dut__xxx__start = 1'b1;
    idle_wait(1);
    for (int i = 0; i < 80; i++) begin
      bus.dut__xxx__start = 1'($urandom_range(0, 1));
      idle_wait(1);
    end
    bus.dut__xxx__start = 1'b0;
    idle_wait(100);

    // reset asserted around round 30, then a clean run
    bus.dut__xxx__start = 1'b1;
    idle_wait(1);
    bus.dut__xxx__start = 1'b0;
    idle_wait(39);
    reset = 1'b1;
    idle_wait(1);
    reset = 1'b0;
    idle_wait(20);
    bus.dut__xxx__start = 1'b1;
    idle_wait(1);
    bus.dut__xxx__start = 1'b0;
    idle_wait(95);

    // start held high: back-to-back hashes
    bus.dut__xxx__start = 1'b1;
    idle_wait(3 * (FIN + 2) + 5);
    bus.dut__xxx__start = 1'b0;
    idle_wait(100);

    // sparse random starts
    for (int i = 0; i < 400; i++) begin
      bus.dut__xxx__start = ($urandom_range(0, 31) == 0);
      idle_wait(1);
    end
    bus.dut__xxx__start = 1'b0;
    idle_wait(100);

    #1;
    check("pending_events", q_hr.size() + q_rnd.size() + q_dom.size() + q_fin.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_ctrl.md
Name: sha256_ctrl

Overview:
- Top-level sequencer for the SHA-256 compression datapath (the 8×32-bit working-register block driven by H_read/H_iterate).
- Accepts a start request. Loads initial hash words, issues 64 round cycles with K and W addressing, then streams the 8 final hash words to the output (dom) memory. Pulses done at the end.
- Sits between the testbench/system start-done handshake and the memory ports: hmem, kmem, msg, dom.

Parameters:
- ROUNDS, 64, number of compression rounds; must be a power of two and ≥16.
- OUT_LAT, 2, cycles from the FINAL-phase hmem address to valid final data at the datapath output.
- HW_ADDR, 3, hmem and dom word address width (8 words).
- K_ADDR, 6, kmem address width; equals log2(ROUNDS).
- M_ADDR, 4, msg memory address width (16 words per block).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on clk.
- dut__xxx__start  in  1  start request, level; sampled only in IDLE.
- dut__xxx__finish  out  1  one-cycle done pulse.
- H_read  out  1  datapath load/finalise strobe.
- H_iterate  out  1  datapath round strobe.
- dut__hmem__address  out  HW_ADDR  initial-hash word address.
- dut__kmem__address  out  K_ADDR  round-constant address.
- dut__msg__address  out  M_ADDR  message word address.
- w_load  out  1  high: message scheduler takes msg word; low: scheduler generates W.
- dut__dom__address  out  HW_ADDR  output memory address.
- dut__dom__write  out  1  output memory write enable.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. After reset, every output is 0 and the state is IDLE.
- Reset asserted in any state: the next cycle is IDLE with all outputs 0, counters 0, and the OUT_LAT pipeline cleared. No dom write occurs on that cycle.
- Cycle numbering: cycle 0 is the clk edge at which IDLE samples start=1.
- States and transitions:
  - IDLE: waits for start=1, then goes to LOAD_H.
  - LOAD_H, cycles 1–8: H_read=1; hmem_address = 0..7 (cnt). After cnt=7, goes to GAP_H.
  - GAP_H, 1 cycle: H_read=0, H_iterate=0. Lets the datapath leave its load state. Goes to ROUND.
  - ROUND, ROUNDS cycles: H_iterate=1; kmem_address = round (0..ROUNDS-1).
    - Rounds 0–15: msg_address = round, w_load=1.
    - Rounds ≥16: w_load=0, msg_address holds 0.
    - After round = ROUNDS-1, goes to GAP_R.
  - GAP_R, 1 cycle: all strobes 0. Goes to FINAL.
  - FINAL, 8 cycles: H_read=1; hmem_address = 0..7. Each cycle pushes (valid=1, addr=cnt) into an OUT_LAT-deep shift register. Goes to DRAIN.
  - DRAIN, OUT_LAT cycles: H_read=0; the shift register keeps emptying. Goes to DONE.
  - DONE, 1 cycle: finish=1. Goes to IDLE. busy is 0 from the following cycle.
- Output writes: dom_write/dom_address are the shift-register tail. Exactly 8 writes, addresses 0..7 in order, each OUT_LAT cycles after the matching hmem address.
- Counters: one shared 6-bit cnt, cleared on every state change. No wrap inside a phase; exit is decided on the terminal count.
- start held high: after DONE, IDLE samples it again, so back-to-back hashes are allowed. start is ignored while busy.
- Address outputs not listed for a state hold 0.
- Total latency with ROUNDS=64, OUT_LAT=2: finish pulses at cycle 1+8+1+64+1+8+2 = 85.

Optional Feature:
- SHA_CTRL_CYCLE_CNT_EN
  - Defined: adds output cycle_count [15:0]. It clears when IDLE accepts start, increments every busy cycle, saturates at 16'hFFFF, and holds its value after DONE until the next start. Reset value is 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sha_pkg:
  - State encoding typedef for the controller states: IDLE, LOAD_H, GAP_H, ROUND, GAP_R, FINAL, DRAIN, DONE.
  - Constants NUM_HWORDS=8, NUM_MWORDS=16, NUM_ROUNDS=64.
- Sub-module sha256_ctrl_outpipe: the OUT_LAT-deep valid/address shift register with synchronous clear. Natural and reusable.
- Everything else stays in one FSM module.

Test Plan:
- Reset, then start=1 for one cycle → busy=1 at cycle 1; hmem_address reads 0..7 over cycles 1–8 with H_read=1; H_read=0 at cycle 9.
- Full run with ROUNDS=64 → H_iterate=1 for exactly 64 consecutive cycles (10–73); kmem_address 0..63; w_load=1 only for the first 16.
- Output check → dom_write=1 on cycles 77–84 with addresses 0..7; finish=1 only at cycle 85; busy=0 at cycle 86.
- Reset asserted at round 30 → all outputs 0 next cycle, zero dom writes; a fresh start then completes normally in 85 cycles.
- start held high continuously → second hash begins LOAD_H at cycle 87 (IDLE at 86 accepts); pulses mid-run have no effect.
- SHA_CTRL_CYCLE_CNT_EN defined → cycle_count = 85 after DONE, unchanged while idle, and cleared on the next accepted start.
